eth_tx_frame_gen: RTL and testbench
===================================

// Module: eth_tx_frame_gen
// PURPOSE
//  Test-frame source feeding the eth_mac transmit byte stream, in the clk_mac domain.
//  A rising edge on start emits one complete Ethernet II frame (no preamble/FCS; MAC adds them).
//  Frame layout: DST_MAC, SRC_MAC, ETHERTYPE, then a payload driven by cfg_fill/cfg_len (board switches).
// PARAMETERS
//  DST_MAC    48'hFFFF_FFFF_FFFF  destination address, sent MSB byte first
//  SRC_MAC    48'h0200_0000_0001  source address, sent MSB byte first
//  ETHERTYPE  16'h88B5            type field, sent MSB byte first
//  IFG_CYCLES 12                  idle cycles after tx_last transfer before start is accepted again (>=1)
// PORTS
//  clk_mac     in   1   sole clock
//  rst         in   1   synchronous reset, active-high
//  start       in   1   level (debounced button); rising edge requests one frame
//  cfg_len     in   11  payload length in bytes; latched at accepted start
//  cfg_fill    in   8   payload seed byte; latched at accepted start
//  tx_data     out  8   frame byte
//  tx_valid    out  1   tx_data/tx_last valid
//  tx_ready    in   1   downstream accepts byte when tx_valid && tx_ready
//  tx_last     out  1   marks final frame byte
//  busy        out  1   high in any state other than IDLE
//  frame_count out  16  frames completed; wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: state IDLE; tx_valid=0, tx_last=0, tx_data=0, busy=0, frame_count=0.
//  Reset also clears the start edge detector's previous-value register to 0.
//  Edge detect: start_q registered each cycle; edge = start & ~start_q. Edge accepted only in IDLE.
//  Edges while busy are dropped, not queued. start held high produces exactly one frame.
//  Length clamp at latch: len = (cfg_len<46) ? 46 : (cfg_len>1500) ? 1500 : cfg_len.
//  FSM: IDLE -> HDR (edge) -> PAY -> GAP -> IDLE.
//   HDR: idx 0..13 = DST_MAC[47:40]..[7:0], SRC_MAC[47:40]..[7:0], ETHERTYPE[15:8], [7:0].
//   PAY: idx 0..len-1; byte = cfg_fill_latched + idx[7:0] (mod 256).
//   Header idx 13 accepted -> PAY idx 0.
//   tx_last=1 only on PAY idx len-1.
//   Transfer of that byte -> GAP; frame_count++.
//   GAP: tx_valid=0; count IFG_CYCLES cycles -> IDLE.
//  First cycle: tx_valid rises the cycle after the accepted edge (1-cycle latency); busy rises the same cycle.
//  Back-to-back: tx_valid stays high between header and payload bytes while tx_ready=1.
//  Handshake: advance only on tx_valid&tx_ready. While tx_valid&!tx_ready, tx_data/tx_last hold stable.
//  tx_valid never deasserts before its byte is taken.
//  Total bytes per frame = 14 + len (60..1514). Index counter 11 bits, never wraps within a frame.
//  Reset mid-frame: outputs return to reset values next edge, no tx_last emitted.
//  Reset mid-frame: the MAC is reset by the same rst, so the partial frame is discarded downstream.
// CONFIGURATION
//  FRAME_GEN_SEQ_EN defined: PAY idx 0,1 = frame_count[15:8], frame_count[7:0] (value before increment).
//   Pattern resumes at idx 2 as cfg_fill+idx.
//  FRAME_GEN_SEQ_EN undefined: every payload byte follows the cfg_fill+idx pattern; no sequence field.
// TESTING
//  Frame 1: rst, cfg_len=46, cfg_fill=00, tx_ready=1, start pulse -> 60 transfers.
//   Expect bytes0-5=FF, bytes6-11=02 00 00 00 00 01, bytes12-13=88 B5, byte14=00, byte59=2D.
//   Expect tx_last only on byte 59; frame_count=1.
//  Clamp: cfg_len=10 -> 60 bytes.
//  Clamp: cfg_len=2000 -> 1514 bytes, last payload byte=(fill+1499)&FF.
//  Clamp: cfg_len=1500, fill=F0 -> payload wraps F0..FF,00..; 1514 bytes.
//  Backpressure: random tx_ready (~50%) -> byte sequence identical to tx_ready=1 run.
//   Data/last stable during stalls.
//  start held high 10000 cycles -> exactly one frame.
//  Second edge during busy -> ignored.
//  Edge 1 cycle after GAP ends -> accepted.
//  rst asserted at payload byte 20 -> tx_valid=0, busy=0, frame_count=0 next cycle.
//   Next start gives a full 60-byte frame.
//  FRAME_GEN_SEQ_EN: three frames, fill=00 -> payload bytes 0-1 read 00 00, 00 01, 00 02; byte16 of each=02.

Source files
------------

// File: rtl/eth_tx_frame_gen.sv
// Test-frame source: one Ethernet II frame (header + fill pattern payload) per rising edge of start.
// Optional build macro FRAME_GEN_SEQ_EN puts frame_count into the first two payload bytes.
module eth_tx_frame_gen #(
    parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC    = 48'h0200_0000_0001,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic        clk_mac,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] cfg_len,
    input  logic [7:0]  cfg_fill,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2, GAP = 2'd3} state_t;

    state_t      state_r, state_s;
    logic [10:0] idx_r, idx_s;
    logic [10:0] len_r, len_s;
    logic [7:0]  fill_r, fill_s;
    logic [15:0] gap_r, gap_s;
    logic [15:0] count_r, count_s;
    logic [7:0]  data_r, data_s;
    logic        valid_r, valid_s;
    logic        last_r, last_s;
    logic        busy_r, busy_s;
    logic        start_q_r;
    logic        edge_s;
    logic        xfer_s;
    logic [10:0] idx_inc_s;
    logic [10:0] len_last_s;

    function automatic logic [7:0] hdr_byte(input logic [3:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = DST_MAC[47:40];
            4'd1:    b = DST_MAC[39:32];
            4'd2:    b = DST_MAC[31:24];
            4'd3:    b = DST_MAC[23:16];
            4'd4:    b = DST_MAC[15:8];
            4'd5:    b = DST_MAC[7:0];
            4'd6:    b = SRC_MAC[47:40];
            4'd7:    b = SRC_MAC[39:32];
            4'd8:    b = SRC_MAC[31:24];
            4'd9:    b = SRC_MAC[23:16];
            4'd10:   b = SRC_MAC[15:8];
            4'd11:   b = SRC_MAC[7:0];
            4'd12:   b = ETHERTYPE[15:8];
            4'd13:   b = ETHERTYPE[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

`ifdef FRAME_GEN_SEQ_EN
    function automatic logic [7:0] pay_byte(input logic [10:0] i, input logic [7:0] fill,
                                            input logic [15:0] cnt);
        logic [7:0] b;
        if (i == 11'd0) begin
            b = cnt[15:8];
        end else if (i == 11'd1) begin
            b = cnt[7:0];
        end else begin
            b = fill + i[7:0];
        end
        return b;
    endfunction
`else
    function automatic logic [7:0] pay_byte(input logic [7:0] i, input logic [7:0] fill);
        return fill + i;
    endfunction
`endif

    function automatic logic [10:0] clamp_len(input logic [10:0] l);
        logic [10:0] r;
        if (l < 11'd46) begin
            r = 11'd46;
        end else if (l > 11'd1500) begin
            r = 11'd1500;
        end else begin
            r = l;
        end
        return r;
    endfunction

    assign edge_s     = start & ~start_q_r;
    assign xfer_s     = valid_r & tx_ready;
    assign idx_inc_s  = idx_r + 11'd1;
    assign len_last_s = len_r - 11'd1;

    // State, datapath and output registers.
    always_ff @(posedge clk_mac) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= 11'd0;
            len_r     <= 11'd0;
            fill_r    <= 8'h00;
            gap_r     <= 16'd0;
            count_r   <= 16'd0;
            data_r    <= 8'h00;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b0;
            start_q_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            len_r     <= len_s;
            fill_r    <= fill_s;
            gap_r     <= gap_s;
            count_r   <= count_s;
            data_r    <= data_s;
            valid_r   <= valid_s;
            last_r    <= last_s;
            busy_r    <= busy_s;
            start_q_r <= start;
        end
    end

    // Next-state logic; the next byte is precomputed so outputs leave straight from registers.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        len_s   = len_r;
        fill_s  = fill_r;
        gap_s   = gap_r;
        count_s = count_r;
        data_s  = data_r;
        valid_s = valid_r;
        last_s  = last_r;
        busy_s  = busy_r;
        case (state_r)
            IDLE: begin
                if (edge_s) begin
                    state_s = HDR;
                    idx_s   = 11'd0;
                    len_s   = clamp_len(cfg_len);
                    fill_s  = cfg_fill;
                    data_s  = hdr_byte(4'd0);
                    valid_s = 1'b1;
                    last_s  = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            HDR: begin
                if (xfer_s && idx_r == 11'd13) begin
                    state_s = PAY;
                    idx_s   = 11'd0;
`ifdef FRAME_GEN_SEQ_EN
                    data_s  = pay_byte(11'd0, fill_r, count_r);
`else
                    data_s  = pay_byte(8'd0, fill_r);
`endif
                    last_s  = (len_r == 11'd1);
                end else if (xfer_s) begin
                    idx_s   = idx_inc_s;
                    data_s  = hdr_byte(idx_inc_s[3:0]);
                end else begin
                    state_s = HDR;
                end
            end
            PAY: begin
                // Leaving PAY on the final transfer is the only place frame_count moves.
                if (xfer_s && idx_r == len_last_s) begin
                    state_s = GAP;
                    gap_s   = 16'd0;
                    count_s = count_r + 16'd1;
                    data_s  = 8'h00;
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                end else if (xfer_s) begin
                    idx_s   = idx_inc_s;
`ifdef FRAME_GEN_SEQ_EN
                    data_s  = pay_byte(idx_inc_s, fill_r, count_r);
`else
                    data_s  = pay_byte(idx_inc_s[7:0], fill_r);
`endif
                    last_s  = (idx_inc_s == len_last_s);
                end else begin
                    state_s = PAY;
                end
            end
            GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                end else begin
                    gap_s   = gap_r + 16'd1;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                last_s  = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign tx_data     = data_r;
    assign tx_valid    = valid_r;
    assign tx_last     = last_r;
    assign busy        = busy_r;
    assign frame_count = count_r;

endmodule

// File: tb/tb_eth_tx_frame_gen.sv
// Directed bench for eth_tx_frame_gen: header bytes, fill pattern, length clamps,
// backpressure stability, edge handling, inter-frame gap and mid-frame reset.
module tb_eth_tx_frame_gen;

    logic        clk_mac = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] cfg_len;
    logic [7:0]  cfg_fill;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic [15:0] frame_count;

    localparam logic [111:0] HDR_EXP = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h88B5};

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  cap_data [0:2047];
    logic        cap_last [0:2047];
    int          cap_n;
    logic [15:0] exp_count;

    eth_tx_frame_gen dut (
        .clk_mac     (clk_mac),
        .rst         (rst),
        .start       (start),
        .cfg_len     (cfg_len),
        .cfg_fill    (cfg_fill),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_last     (tx_last),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk_mac = ~clk_mac;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_mac);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Capture one frame; also checks that a stalled byte is held unchanged.
    task automatic collect(input bit rnd, input int budget);
        logic       hold_v;
        logic [7:0] hold_d;
        logic       hold_l;
        bit         done;
        cap_n  = 0;
        done   = 1'b0;
        hold_v = 1'b0;
        hold_d = 8'h00;
        hold_l = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk_mac);
            if (hold_v) begin
                check_eq("stall_valid", 32'(tx_valid), 32'd1);
                check_eq("stall_data", 32'(tx_data), 32'(hold_d));
                check_eq("stall_last", 32'(tx_last), 32'(hold_l));
            end
            hold_v = tx_valid && !tx_ready;
            hold_d = tx_data;
            hold_l = tx_last;
            if (tx_valid && tx_ready && cap_n < 2048) begin
                cap_data[cap_n] = tx_data;
                cap_last[cap_n] = tx_last;
                cap_n++;
                if (tx_last) done = 1'b1;
            end
            tick();
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check_eq("frame_done", 32'(done), 32'd1);
        tx_ready = 1'b1;
    endtask

    task automatic verify(input string tag, input int plen, input logic [7:0] fill);
        logic [111:0] hdr_v;
        logic [7:0]   e;
        hdr_v = HDR_EXP;
        check_eq({tag, "_nbytes"}, 32'(cap_n), 32'(14 + plen));
        for (int i = 0; i < cap_n && i < 14 + plen; i++) begin
            if (i < 14) begin
                e = hdr_v[111 - 8 * i -: 8];
            end else begin
`ifdef FRAME_GEN_SEQ_EN
                if (i == 14)      e = exp_count[15:8];
                else if (i == 15) e = exp_count[7:0];
                else              e = fill + 8'(i - 14);
`else
                e = fill + 8'(i - 14);
`endif
            end
            check_eq({tag, "_byte"}, 32'(cap_data[i]), 32'(e));
            check_eq({tag, "_last"}, 32'(cap_last[i]), 32'(i == 13 + plen));
        end
        exp_count = exp_count + 16'd1;
        check_eq({tag, "_count"}, 32'(frame_count), 32'(exp_count));
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 200) begin
            tick();
            c++;
        end
        check_eq("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int vcount;
        rst       = 1'b1;
        start     = 1'b0;
        tx_ready  = 1'b1;
        cfg_len   = 11'd46;
        cfg_fill  = 8'h00;
        exp_count = 16'd0;
        repeat (3) tick();
        check_eq("rst_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_last", 32'(tx_last), 32'd0);
        check_eq("rst_data", 32'(tx_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_count", 32'(frame_count), 32'd0);
        rst = 1'b0;
        tick();

        // Frame 1: minimum payload, 60 bytes.
        pulse_start();
        check_eq("first_valid", 32'(tx_valid), 32'd1);
        check_eq("first_busy", 32'(busy), 32'd1);
        collect(1'b0, 200);
        verify("f1", 46, 8'h00);
        check_eq("f1_b14", 32'(cap_data[14]), 32'h00);
        check_eq("f1_b59", 32'(cap_data[59]), 32'h2D);

        // Gap is 12 cycles; an edge right after it must be accepted.
        repeat (11) tick();
        check_eq("gap_busy", 32'(busy), 32'd1);
        check_eq("gap_valid", 32'(tx_valid), 32'd0);
        tick();
        check_eq("gap_end_busy", 32'(busy), 32'd0);
        cfg_len  = 11'd10;
        cfg_fill = 8'h11;
        pulse_start();
        check_eq("gap_edge_accept", 32'(tx_valid), 32'd1);
        collect(1'b0, 200);
        verify("clamp_lo", 46, 8'h11);

        wait_idle();
        cfg_len  = 11'd2000;
        cfg_fill = 8'h00;
        pulse_start();
        collect(1'b0, 2000);
        verify("clamp_hi", 1500, 8'h00);
        check_eq("clamp_hi_lastb", 32'(cap_data[1513]), 32'hDB);

        wait_idle();
        cfg_len  = 11'd1500;
        cfg_fill = 8'hF0;
        pulse_start();
        collect(1'b0, 2000);
        verify("wrap", 1500, 8'hF0);
        check_eq("wrap_ff", 32'(cap_data[29]), 32'hFF);
        check_eq("wrap_00", 32'(cap_data[30]), 32'h00);
        check_eq("wrap_lastb", 32'(cap_data[1513]), 32'hCB);

        // Random backpressure must not change the byte stream.
        wait_idle();
        cfg_len  = 11'd46;
        cfg_fill = 8'h00;
        pulse_start();
        collect(1'b1, 1000);
        verify("bp", 46, 8'h00);

        // Second edge while stalled in the header is dropped.
        wait_idle();
        cfg_fill = 8'h33;
        tx_ready = 1'b0;
        pulse_start();
        repeat (3) tick();
        pulse_start();
        tx_ready = 1'b1;
        collect(1'b0, 200);
        verify("busy_edge", 46, 8'h33);
        wait_idle();
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tx_valid) vcount++;
        end
        check_eq("no_queued", 32'(vcount), 32'd0);

        // start held high yields one frame only.
        start = 1'b1;
        tick();
        collect(1'b0, 200);
        verify("hold", 46, 8'h33);
        vcount = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (tx_valid) vcount++;
        end
        check_eq("hold_one", 32'(vcount), 32'd0);
        check_eq("hold_count", 32'(frame_count), 32'(exp_count));
        start = 1'b0;
        tick();

        // Reset at payload byte 20.
        pulse_start();
        repeat (34) tick();
        check_eq("pre_rst_valid", 32'(tx_valid), 32'd1);
        check_eq("pre_rst_data", 32'(tx_data), 32'h47);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_valid", 32'(tx_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_count", 32'(frame_count), 32'd0);
        check_eq("mid_rst_last", 32'(tx_last), 32'd0);
        exp_count = 16'd0;
        rst = 1'b0;
        tick();

        // Three frames with fill 00 after reset.
        cfg_fill = 8'h00;
        for (int f = 0; f < 3; f++) begin
            pulse_start();
            collect(1'b0, 200);
            verify("post_rst", 46, 8'h00);
            check_eq("post_rst_b16", 32'(cap_data[16]), 32'h02);
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
